// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row scan, 2-flop column sync, press/release debounce, key encode.
// Define KEYPAD_AUTOREPEAT_EN to re-strobe enter every REPEAT_CYCLES while a key is held.
module keypad_scanner #(
    parameter int unsigned SCAN_CYCLES     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned REPEAT_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] keypad_input,
    output logic       enter,
    output logic       key_held
);

    localparam int unsigned DwellW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 2;
    localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_CYCLES - 1);
    localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StScan, StDebounce, StPressed, StReleaseDeb} state_e;

    state_e            state_q, state_d;
    logic [1:0]        row_q, row_d;
    logic [1:0]        col_q, col_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [DebW-1:0]   deb_q, deb_d;
    logic [3:0]        sync1_q, sync1_d;
    logic [3:0]        sync2_q, sync2_d;
    logic [3:0]        code_q, code_d;
    logic              enter_q, enter_d;
    logic              held_q, held_d;
    logic [3:0]        col_s;
    logic [1:0]        col_pick;
    logic              key_low;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RepW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);
    logic [RepW-1:0] rep_q, rep_d;
`endif

    assign col_s        = sync2_q;
    assign key_low      = ~col_s[col_q];
    assign row_n        = ~(4'b0001 << row_q);
    assign keypad_input = code_q;
    assign enter        = enter_q;
    assign key_held     = held_q;

    // Descending loop so the lowest-index low column wins.
    always_comb begin
        col_pick = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_s[i]) col_pick = 2'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        deb_d   = deb_q;
        sync1_d = col_n;
        sync2_d = sync1_q;
        code_d  = code_q;
        enter_d = 1'b0;
        held_d  = held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif
        unique case (state_q)
            StScan: begin
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    if (col_s != 4'b1111) begin
                        col_d   = col_pick;
                        deb_d   = '0;
                        state_d = StDebounce;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            StDebounce: begin
                if (key_low) begin
                    if (deb_q == DebLast) begin
                        deb_d   = '0;
                        state_d = StPressed;
                        code_d  = {row_q, col_q};
                        enter_d = 1'b1;
                        held_d  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d   = '0;
`endif
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    // Bounce: retry the same row from the start of its dwell.
                    state_d = StScan;
                    dwell_d = '0;
                end
            end
            StPressed: begin
                if (!key_low) begin
                    state_d = StReleaseDeb;
                    deb_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d   = '0;
`endif
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (rep_q == RepLast) begin
                    enter_d = 1'b1;
                    rep_d   = '0;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
`endif
            end
            StReleaseDeb: begin
                if (!key_low) begin
                    if (deb_q == DebLast) begin
                        deb_d   = '0;
                        held_d  = 1'b0;
                        state_d = StScan;
                        row_d   = row_q + 2'd1;
                        dwell_d = '0;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    state_d = StPressed;
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StScan;
            row_q   <= '0;
            col_q   <= '0;
            dwell_q <= '0;
            deb_q   <= '0;
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
            code_q  <= '0;
            enter_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dwell_q <= dwell_d;
            deb_q   <= deb_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            code_q  <= code_d;
            enter_q <= enter_d;
            held_q  <= held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives col_n from row_n and a pressed-key map.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] keypad_input;
    logic       enter;
    logic       key_held;

    logic [15:0] pressed = '0;
    logic [3:0]  col_force_n = 4'b1111;
    logic [3:0]  cols;
    logic [3:0]  exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        cols = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !row_n[r]) cols[c] = 1'b0;
            end
        end
    end

    assign col_n = cols & col_force_n;

    keypad_scanner dut (
        .clk          (clk),
        .reset        (reset),
        .col_n        (col_n),
        .row_n        (row_n),
        .keypad_input (keypad_input),
        .enter        (enter),
        .key_held     (key_held)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name, input int limit);
        int i = 0;
        while (exp_q.size() != 0 && i < limit) begin
            @(negedge clk);
            i++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected enter strobes missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every enter strobe pops the next expected key code.
    always @(negedge clk) begin
        if (!reset && enter) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_enter: got enter with code %0d, expected no enter",
                         keypad_input);
            end else begin
                check("enter_code", keypad_input, exp_q.pop_front());
                check("held_on_enter", key_held, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0] prev;
        logic [3:0] seq [4];

        // Reset values
        cycles(3);
        check("reset_row_n", row_n, 4'b1110);
        check("reset_code", keypad_input, 0);
        check("reset_enter", enter, 0);
        check("reset_held", key_held, 0);

        // Idle scan: each row held SCAN_CYCLES clocks, wrapping after row 3
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            check("idle_row_n", row_n, int'(~(4'b0001 << ((k / 4) % 4))) & 15);
            @(negedge clk);
        end
        check("idle_code", keypad_input, 0);

        // Single press of row1/col0, release debounce timing
        pressed[4] = 1'b1;
        exp_q.push_back(4'd4);
        cycles(40);
        check("press4_held", key_held, 1);
        pressed[4] = 1'b0;
        n = 0;
        while (key_held && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_range("release_drop_cycles", n, 9, 11);
        drain("press4_drain", 10);
        cycles(30);

        // Bounce on row 0 col 2: no enter, scan stays on row 0
        prev = row_n;
        n = 0;
        while (!(row_n == 4'b1110 && prev == 4'b0111) && n < 40) begin
            prev = row_n;
            @(negedge clk);
            n++;
        end
        col_force_n = 4'b1011;
        n = 1;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (i == 3) col_force_n = 4'b1111;
            if (row_n == 4'b1110) n++;
            else break;
        end
        check_range("bounce_row0_dwell", n, 9, 11);
        check("bounce_code_kept", keypad_input, 4);
        check("bounce_held", key_held, 0);
        cycles(10);

        // Sequence 4,5,6,7
        seq[0] = 4'd4; seq[1] = 4'd5; seq[2] = 4'd6; seq[3] = 4'd7;
        for (int i = 0; i < 4; i++) begin
            pressed[seq[i]] = 1'b1;
            exp_q.push_back(seq[i]);
            cycles(30);
            pressed[seq[i]] = 1'b0;
            cycles(30);
        end
        drain("sequence_drain", 10);
        check("sequence_last_code", keypad_input, 7);

        // Two keys on row 2: lowest column wins; short release glitch ignored
        pressed[9]  = 1'b1;
        pressed[11] = 1'b1;
        exp_q.push_back(4'd9);
        cycles(35);
        check("multi_held", key_held, 1);
        pressed[9]  = 1'b0;
        pressed[11] = 1'b0;
        cycles(4);
        pressed[9]  = 1'b1;
        pressed[11] = 1'b1;
        cycles(20);
        check("glitch_held", key_held, 1);
        pressed[9]  = 1'b0;
        pressed[11] = 1'b0;
        cycles(30);
        drain("multi_drain", 10);
        check("multi_released", key_held, 0);

        // Reset while pressed, key still held afterwards
        pressed[14] = 1'b1;
        exp_q.push_back(4'd14);
        cycles(35);
        drain("pre_reset_drain", 10);
        reset = 1'b1;
        #1;
        check("midreset_row_n", row_n, 4'b1110);
        check("midreset_code", keypad_input, 0);
        check("midreset_enter", enter, 0);
        check("midreset_held", key_held, 0);
        cycles(3);
        exp_q.push_back(4'd14);
        reset = 1'b0;
        cycles(40);
        drain("post_reset_drain", 10);
        check("post_reset_held", key_held, 1);
        pressed[14] = 1'b0;
        cycles(30);
        check("post_reset_released", key_held, 0);

`ifdef KEYPAD_AUTOREPEAT_EN
        // Long hold: enters at entry, +64, +128
        pressed[2] = 1'b1;
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd2);
        n = 0;
        while (!enter && n < 60) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!enter && n < 100);
        check("repeat_interval", n, 64);
        cycles(70);
        pressed[2] = 1'b0;
        cycles(30);
        drain("repeat_drain", 10);
`endif

        cycles(5);
        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
